// File: rtl/add_shift_mul_ctrl.sv
// Sequential shift-add 32x32->64 multiplier built around one shared 32-bit Adder.
// Define MUL_SIGNED_EN to honour signed_op (adds operand/result negation states).

module Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] dout,
    output logic        cout
);
    assign dout = a + b + {31'b0, sel};
    // Legacy quirk: this port mirrors the sum MSB, not the carry.
    assign cout = dout[31];
endmodule

module add_shift_mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
`ifdef MUL_SIGNED_EN
    typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, RUN, NEG_LO, NEG_HI, DONE} state_t;
    localparam state_t FIRST = NEG_A;
    localparam state_t AFTER_RUN = NEG_LO;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam state_t FIRST = RUN;
    localparam state_t AFTER_RUN = DONE;
`endif

    state_t      state, next;
    logic [31:0] mcand, hi, lo;
    logic [4:0]  cnt;
    logic        accept;
    logic [31:0] add_a, add_b, sum;
    logic        add_sel, carry;
    logic        adder_cout_unused;
`ifdef MUL_SIGNED_EN
    logic        neg, cy, sgn;
`else
    logic        signed_unused;
    assign signed_unused = signed_op;
`endif

    Adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .sel  (add_sel),
        .dout (sum),
        .cout (adder_cout_unused)
    );

    // True carry-out recovered from operand MSBs and the sum MSB.
    assign carry = (add_a[31] & add_b[31]) | ((add_a[31] | add_b[31]) & ~sum[31]);

    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign product = {hi, lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next    = state;
        accept  = 1'b0;
        add_a   = hi;
        add_b   = mcand;
        add_sel = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    next   = FIRST;
                end
            end
            RUN: begin
                if (cnt == 5'd31) next = AFTER_RUN;
            end
`ifdef MUL_SIGNED_EN
            NEG_A: begin
                add_a   = '0;
                add_b   = ~mcand;
                add_sel = 1'b1;
                next    = NEG_B;
            end
            NEG_B: begin
                add_a   = '0;
                add_b   = ~lo;
                add_sel = 1'b1;
                next    = RUN;
            end
            NEG_LO: begin
                add_a   = '0;
                add_b   = ~lo;
                add_sel = 1'b1;
                next    = NEG_HI;
            end
            NEG_HI: begin
                add_a   = '0;
                add_b   = ~hi;
                add_sel = cy;
                next    = DONE;
            end
`endif
            DONE: begin
                if (start) begin
                    accept = 1'b1;
                    next   = FIRST;
                end else begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
`ifdef MUL_SIGNED_EN
            neg   <= 1'b0;
            cy    <= 1'b0;
            sgn   <= 1'b0;
`endif
        end else if (accept) begin
            mcand <= op_a;
            lo    <= op_b;
            hi    <= '0;
            cnt   <= '0;
`ifdef MUL_SIGNED_EN
            sgn   <= signed_op;
            neg   <= signed_op & (op_a[31] ^ op_b[31]);
`endif
        end else begin
            case (state)
                RUN: begin
                    if (lo[0]) {hi, lo} <= {carry, sum, lo[31:1]};
                    else       {hi, lo} <= {1'b0, hi, lo[31:1]};
                    cnt <= cnt + 5'd1;
                end
`ifdef MUL_SIGNED_EN
                NEG_A:  if (sgn && mcand[31]) mcand <= sum;
                NEG_B:  if (sgn && lo[31]) lo <= sum;
                NEG_LO: begin
                    if (neg) begin
                        lo <= sum;
                        cy <= carry;
                    end else begin
                        cy <= 1'b0;
                    end
                end
                NEG_HI: if (neg) hi <= sum;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_shift_mul_ctrl.sv
// Self-checking bench for add_shift_mul_ctrl; follows MUL_SIGNED_EN like the RTL.

module tb_add_shift_mul_ctrl;
`ifdef MUL_SIGNED_EN
    localparam int LAT = 36;
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam int LAT = 32;
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [63:0] product;

    int checks = 0;
    int failures = 0;

    add_shift_mul_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] xa, xb;
        if (SIGNED_BUILD && s) begin
            xa = {{32{a[31]}}, a};
            xb = {{32{b[31]}}, b};
        end else begin
            xa = {32'b0, a};
            xb = {32'b0, b};
        end
        return xa * xb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Drive a request and step past the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        op_a = a;
        op_b = b;
        signed_op = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    // Returns inside the DONE cycle.
    task automatic wait_done(input string name, input logic [63:0] exp, input int already);
        int cyc = already;
        while (!done && cyc < LAT + 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(LAT));
        chk({name, "_busy_low"}, {63'b0, busy}, 64'd0);
        chk({name, "_product"}, product, exp);
    endtask

    task automatic check_idle(input string name, input logic [63:0] exp);
        @(posedge clk);
        #1;
        chk({name, "_done_one_cycle"}, {62'b0, busy, done}, 64'd0);
        chk({name, "_product_hold"}, product, exp);
    endtask

    vec_t tbl[$];

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] first_exp;

        #2;
        chk("reset_outputs", {busy, done, product[61:0]}, 64'd0);
        chk("reset_product", product, 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back('{32'd7, 32'd6, 1'b0, 64'h00000000_0000002A});
        tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001});
        tbl.push_back('{32'd0, 32'hDEADBEEF, 1'b0, 64'd0});
        tbl.push_back('{32'h80000000, 32'd2, 1'b0, 64'h00000001_00000000});
`ifdef MUL_SIGNED_EN
        tbl.push_back('{32'hFFFFFFFF, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFE});
        tbl.push_back('{32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1});
        tbl.push_back('{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000});
        tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001});
        tbl.push_back('{32'd5, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFF1});
        tbl.push_back('{32'd0, 32'hFFFFFFFF, 1'b1, 64'd0});
`else
        tbl.push_back('{32'hFFFFFFFF, 32'd2, 1'b1, 64'h00000001_FFFFFFFE});
`endif

        foreach (tbl[i]) begin
            launch(tbl[i].a, tbl[i].b, tbl[i].s);
            wait_done($sformatf("vec%0d", i), tbl[i].exp, 0);
            check_idle($sformatf("vec%0d", i), tbl[i].exp);
        end

        // start pulse while busy must be ignored
        first_exp = model(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        op_a = 32'd3;
        op_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_start", first_exp, 5);
        check_idle("ignored_start", first_exp);

        // back-to-back: start held in the DONE cycle
        launch(32'd100, 32'd200, 1'b0);
        wait_done("b2b_first", 64'd20000, 0);
        launch(32'hFFFF_0000, 32'h0001_0001, 1'b0);
        wait_done("b2b_second", model(32'hFFFF_0000, 32'h0001_0001, 1'b0), 0);
        check_idle("b2b_second", model(32'hFFFF_0000, 32'h0001_0001, 1'b0));

        // reset mid-run aborts immediately
        launch(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_flags", {62'b0, busy, done}, 64'd0);
        chk("midrun_reset_product", product, 64'd0);
        @(posedge clk);
        #1;
        chk("reset_held_flags", {62'b0, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(32'd9, 32'd9, 1'b0);
        wait_done("post_reset", 64'h51, 0);
        check_idle("post_reset", 64'h51);

        // randomized against the arithmetic model
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (n % 5 == 0) ra[31] = 1'b1;
            if (n % 7 == 0) rb[31] = 1'b1;
            launch(ra, rb, rs);
            wait_done($sformatf("rand%0d", n), model(ra, rb, rs), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
